// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative unsigned multiply / divide unit. One operation runs for exactly
// WIDTH iterations (one per clock) regardless of operand values:
//   - MUL : shift-add, result = low WIDTH bits of a*b
//   - DIV : restoring division, result = floor(a/b)
//   - REM : restoring division, result = a mod b
//   - 11  : reserved, result = 0
// Dividing by zero yields all-ones (DIV) or a (REM) and raises div_by_zero.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   begin an operation (honoured only when idle)
//   op[1:0]      in   00 MUL, 01 DIV, 10 REM, 11 reserved
//   a[WIDTH-1:0] in   multiplicand / dividend
//   b[WIDTH-1:0] in   multiplier / divisor
//   busy         out  operation in progress (RUN or DONE)
//   done         out  one-cycle pulse, result valid
//   result       out  product low bits, quotient or remainder (held)
//   div_by_zero  out  DIV/REM with b = 0, valid alongside done
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e state_q, state_d;

  // Datapath registers. Their meaning depends on the latched operation:
  //   MUL     : acc = running product, x = shifted multiplicand,
  //             y = shifted multiplier
  //   DIV/REM : acc = partial remainder, x = dividend shifting out at the
  //             top while quotient bits shift in at the bottom, y = divisor
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       op_q,     op_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] x_q,      x_d;
  logic [WIDTH-1:0] y_q,      y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q,    dbz_d;

  logic             last_iter;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    result      = result_q;
    div_by_zero = dbz_q;
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm, computed from the current registers
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_acc   = acc_q + (y_q[0] ? x_q : '0);

    // Bring the next dividend bit (MSB first) into the partial remainder and
    // trial-subtract the divisor. The partial remainder is always below the
    // divisor (or, for b = 0, holds fewer than WIDTH dividend bits), so
    // rem_shift never uses its top bit and a set top bit of the difference
    // means the subtraction borrowed.
    rem_shift = {acc_q, x_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, y_q};
    div_ok    = ~rem_diff[WIDTH];
    rem_next  = div_ok ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {x_q[WIDTH-2:0], div_ok};
    // With b = 0 every trial subtraction succeeds, so the quotient naturally
    // ends as all ones and the remainder as a, with no special case needed.
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    dbz_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          x_d   = a;
          y_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        unique case (op_q)
          OP_MUL: begin
            acc_d = mul_acc;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
          end
          OP_DIV, OP_REM: begin
            acc_d = rem_next;
            x_d   = quo_next;
          end
          default: ;
        endcase

        // The final iteration's outcome goes straight into result so it is
        // valid together with done and never shows intermediate values.
        if (last_iter) begin
          unique case (op_q)
            OP_MUL:  result_d = mul_acc;
            OP_DIV:  result_d = quo_next;
            OP_REM:  result_d = rem_next;
            default: result_d = '0;
          endcase
          dbz_d = ((op_q == OP_DIV) || (op_q == OP_REM)) && (y_q == '0);
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not just the control state, so
  // outputs read as zero straight out of reset and an aborted operation
  // leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit. Directed cases plus randomized
// operations, compared against a plain-arithmetic reference model. Outputs
// are sampled on the falling clock edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 19;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last result the DUT should be holding (0 after reset).
  logic [W-1:0] held_result;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the operation's arithmetic meaning.
  function automatic logic [W-1:0] model_result(input logic [W-1:0] av,
                                                input logic [W-1:0] bv,
                                                input logic [1:0]   opv);
    logic [63:0] prod;
    prod = 64'(av) * 64'(bv);
    case (opv)
      2'b00:   return prod[W-1:0];
      2'b01:   return (bv == 0) ? MASK : av / bv;
      2'b10:   return (bv == 0) ? av   : av % bv;
      default: return '0;
    endcase
  endfunction

  function automatic logic model_dbz(input logic [W-1:0] bv, input logic [1:0] opv);
    return ((opv == 2'b01) || (opv == 2'b10)) && (bv == 0);
  endfunction

  // Run one operation and check latency, outputs and post-done behaviour.
  // With inject set, a second start with other operands is driven mid-run
  // and again in the DONE cycle; both must be ignored.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [1:0] opv, input bit inject);
    logic [W-1:0] exp_r;
    logic         exp_z;
    int           k;
    int           dones;
    exp_r = model_result(av, bv, opv);
    exp_z = model_dbz(bv, opv);

    @(negedge clk);
    a = av; b = bv; op = opv; start = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    k = 0;
    dones = 0;
    while (k < 3 * W) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dones++;
        break;
      end
      if (k == W / 2) begin
        check({tag, " busy_run"}, 64'(busy), 64'd1);
        check({tag, " dbz_idle"}, 64'(div_by_zero), 64'd0);
        check({tag, " result_held"}, 64'(result), 64'(held_result));
      end
      if (inject && k == 4) begin
        start = 1'b1;
        a = ~av; b = bv + W'(3); op = opv ^ 2'b01;
      end
    end
    check({tag, " done_seen"}, 64'(dones), 64'd1);
    check({tag, " latency"}, 64'(k), 64'(W));
    check({tag, " result"}, 64'(result), 64'(exp_r));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_z));
    held_result = exp_r;

    if (inject) begin
      start = 1'b1;
      a = ~av; op = 2'b00;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
    check({tag, " dbz_after"}, 64'(div_by_zero), 64'd0);
    check({tag, " result_hold"}, 64'(result), 64'(exp_r));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " result"}, 64'(result), 64'd0);
    check({tag, " dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    held_result = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases
    do_op("mul_7x9",    W'(7),        W'(9),   2'b00, 1'b0);
    do_op("mul_ovf",    W'('h7FFFF),  W'(2),   2'b00, 1'b0);
    do_op("div_100_7",  W'(100),      W'(7),   2'b01, 1'b0);
    do_op("rem_100_7",  W'(100),      W'(7),   2'b10, 1'b0);
    do_op("div_by_0",   W'(5),        W'(0),   2'b01, 1'b0);
    do_op("rem_by_0",   W'(5),        W'(0),   2'b10, 1'b0);
    do_op("reserved",   W'(1234),     W'(56),  2'b11, 1'b0);
    do_op("mul_a0",     W'(0),        W'(77),  2'b00, 1'b0);
    do_op("div_b1",     MASK,         W'(1),   2'b01, 1'b0);
    do_op("rem_b1",     W'(4321),     W'(1),   2'b10, 1'b0);
    do_op("mul_max",    MASK,         MASK,    2'b00, 1'b0);
    do_op("div_small",  W'(3),        MASK,    2'b01, 1'b0);
    do_op("busy_start", W'(1000),     W'(33),  2'b01, 1'b1);

    // Reset during RUN at iteration 10
    @(negedge clk);
    a = W'(999); b = W'(3); op = 2'b00; start = 1'b1;
    @(posedge clk);                 // E0
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);      // iterations 1..9 done
    rst_n = 1'b0;                   // reset edge is E0+10
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    held_result = '0;
    begin
      int seen = 0;
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort no_done", 64'(seen), 64'd0);
    end
    do_op("after_abort", W'(999), W'(3), 2'b00, 1'b0);

    // Reset takes priority over start at the same edge
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; a = W'(8); b = W'(8); op = 2'b00;
    @(negedge clk);
    check("rst_prio busy", 64'(busy), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    held_result = '0;
    @(negedge clk);
    check("rst_prio idle", 64'(busy), 64'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   rop;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: ra = W'($urandom_range(0, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), ra, rb, rop, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
